// File: rtl/alu_op_decode_queue_if.sv
// Fetch-to-decode and decode-to-ALU handshake bundle for alu_op_decode_queue.
// The slave modport is the decode stage; the master modport is its environment
// (fetch on the input side, ALU on the output side).
interface alu_op_decode_queue_if #(
    parameter int unsigned ERRW = 8
);
    // Fetch side
    logic            in_valid;
    logic            in_ready;
    logic [8:0]      instr;
    // ALU side
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      alu_op;
    logic [3:0]      rs;
    logic [7:0]      imm;
    logic            is_imm;
    // Illegal-opcode reporting
    logic            illegal;
    logic [ERRW-1:0] err_count;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, alu_op, rs, imm, is_imm, illegal, err_count
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_op, rs, imm, is_imm, illegal, err_count
    );
endinterface

// File: rtl/alu_op_decode_queue.sv
// Decode stage in front of the ALU: decodes the 5-bit opcode of each accepted
// instruction, queues legal operations in a 2-entry circular buffer and drops
// and counts illegal ones. Handshake outputs depend only on registered count.
module alu_op_decode_queue #(
    parameter int unsigned ERRW = 8
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  flush,
    alu_op_decode_queue_if.slave bus
);

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [3:0] rs;
        logic [7:0] imm;
        logic       is_imm;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              illegal_q, illegal_d;
    logic [ERRW-1:0]   err_count_q, err_count_d;

    entry_t            dec;
    logic              dec_legal;
    logic [4:0]        op;
    logic              accept;
    logic              push;
    logic              pop;
    logic              in_ready;
    logic              out_valid;

    // Opcode decode of the instruction currently offered by fetch
    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        op        = bus.instr[8:4];
        dec.rs    = bus.instr[3:0];
        casez (op)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00111, 5'b01000,
            5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01111: begin
                dec_legal  = 1'b1;
                dec.alu_op = op;
            end
            5'b100??: begin
                // ADDI carries a 2-bit immediate in the opcode's low bits
                dec_legal  = 1'b1;
                dec.alu_op = 5'b10000;
                dec.imm    = {6'b0, op[1:0]};
                dec.is_imm = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Handshake qualifiers, derived from registered count only
    always_comb begin
        in_ready  = (count_q != 2'(DEPTH));
        out_valid = (count_q != 2'd0);
        accept    = bus.in_valid & in_ready;
        push      = accept & dec_legal;
        pop       = out_valid & bus.out_ready;
    end

    // Queue pointer/count/storage and error-count next state
    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        illegal_d   = accept & ~dec_legal;
        err_count_d = err_count_q;

        if (flush) begin
            // Redirect: drop everything, including a push in this cycle
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        // Illegal accounting is independent of flush
        if (illegal_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRW'(1);
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            illegal_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            illegal_q   <= illegal_d;
            err_count_q <= err_count_d;
        end
    end

    // Output drive: head entry fields come straight from storage
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.alu_op    = mem_q[rd_ptr_q].alu_op;
        bus.rs        = mem_q[rd_ptr_q].rs;
        bus.imm       = mem_q[rd_ptr_q].imm;
        bus.is_imm    = mem_q[rd_ptr_q].is_imm;
        bus.illegal   = illegal_q;
        bus.err_count = err_count_q;
    end

endmodule

// File: tb/tb_alu_op_decode_queue.sv
// Self-checking bench for alu_op_decode_queue: directed scenarios followed by
// randomized traffic, checked by a scoreboard built from the opcode table.
module tb_alu_op_decode_queue;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    alu_op_decode_queue_if #(.ERRW(8)) bus ();

    alu_op_decode_queue #(.ERRW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef logic [17:0] ent_t; // {alu_op, rs, imm, is_imm}

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t exp_q[$];
    bit   exp_illegal = 1'b0;
    int   exp_err     = 0;
    bit   started     = 1'b0;
    int   legal_ops[11] = '{0, 1, 2, 3, 7, 8, 9, 10, 11, 12, 15};
    int   illegal_ops[$];

    function automatic bit ref_legal(input logic [8:0] ins);
        int op = int'(ins[8:4]);
        if (op >= 16 && op <= 19) return 1'b1;
        foreach (legal_ops[i]) begin
            if (op == legal_ops[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic ent_t ref_entry(input logic [8:0] ins);
        int         op = int'(ins[8:4]);
        logic [4:0] a;
        logic [7:0] im;
        logic       ii;
        if (op >= 16) begin
            a  = 5'd16;
            im = 8'(op - 16);
            ii = 1'b1;
        end else begin
            a  = 5'(op);
            im = 8'd0;
            ii = 1'b0;
        end
        return {a, ins[3:0], im, ii};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare registered outputs, then apply this cycle's transfer
    bit m_acc;
    bit m_pop;
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
            chk("illegal", 32'(bus.illegal), 32'(exp_illegal));
            chk("err_count", 32'(bus.err_count), 32'(exp_err));
            if (bus.out_valid === 1'b1 && exp_q.size() != 0) begin
                chk("head", 32'({bus.alu_op, bus.rs, bus.imm, bus.is_imm}), 32'(exp_q[0]));
            end
        end
        if (reset) begin
            exp_q.delete();
            exp_illegal = 1'b0;
            exp_err     = 0;
            started     = 1'b1;
        end else begin
            m_acc = bus.in_valid && (exp_q.size() < 2);
            m_pop = bus.out_ready && (exp_q.size() != 0);
            if (m_pop) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            exp_illegal = m_acc && !ref_legal(bus.instr);
            if (m_acc && ref_legal(bus.instr) && !flush) exp_q.push_back(ref_entry(bus.instr));
            if (exp_illegal && exp_err < 255) exp_err++;
        end
    end

    // Offer one instruction until accepted; caller is at posedge+1
    task automatic send(input logic [8:0] ins);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got not-accepted expected accepted for %h", ins);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
        chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
        chk({tag, "_fields"}, 32'({bus.alu_op, bus.rs, bus.imm, bus.is_imm}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int op = 0; op < 32; op++) begin
            if (!ref_legal(9'(op << 4))) illegal_ops.push_back(op);
        end
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b1;

        // Reset and idle values
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_outputs("rst");

        // Basic decode: SUB r3, ADDI with imm 3 and imm 0
        send(9'b00001_0011);
        idle(2);
        send(9'b10011_0101);
        send(9'b10000_0000);
        idle(3);

        // Backpressure: ADD r1, AND r2, SEQ r4 with ALU stalled
        bus.out_ready = 1'b0;
        fork
            begin
                send(9'b00000_0001);
                send(9'b01010_0010);
                send(9'b01100_0100);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle(4);

        // Back-to-back illegals around a legal MOD r7
        send(9'b00100_0000);
        send(9'b01110_0000);
        send(9'b11111_0000);
        send(9'b01111_0111);
        idle(3);

        // Saturation of the illegal counter
        for (int i = 0; i < 256; i++) begin
            send(9'({illegal_ops[$urandom_range(0, illegal_ops.size() - 1)], 4'(i)}));
        end
        idle(2);

        // Push and pop together at count 1
        for (int i = 0; i < 10; i++) begin
            send(9'({legal_ops[i], 4'(i)}));
        end
        idle(3);

        // Flush with a full queue while fetch is offering
        bus.out_ready = 1'b0;
        send(9'b00010_0001);
        send(9'b00011_0010);
        bus.in_valid = 1'b1;
        bus.instr    = 9'b01011_1111;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_full_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Flush with an accepted instruction in the same cycle
        send(9'b00111_0011);
        bus.in_valid = 1'b1;
        bus.instr    = 9'b10010_1110;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_acc_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_acc_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        idle(3);

        // Reset mid-stream with queued entries and a nonzero error count
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) send(9'b11000_0000);
        bus.out_ready = 1'b0;
        send(9'b01001_0110);
        send(9'b10001_1001);
        idle(1);
        reset = 1'b1;
        @(posedge clk);
        chk_reset_outputs("midrst");
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.instr     = 9'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 29) == 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
